// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and helpers for the synchronous FIFO controller
package fifo_pkg;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic empty;
    logic almost_empty;
  } fifo_flags_t;

  localparam fifo_flags_t FLAGS_RESET = '{
    full:         1'b0,
    almost_full:  1'b0,
    empty:        1'b1,
    almost_empty: 1'b1
  };

  function automatic int clogb2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

  // Pointer difference modulo 2^width; the wrap bit makes this the occupancy.
  function automatic logic [31:0] ptr_diff(input logic [31:0] wr_ptr,
                                           input logic [31:0] rd_ptr,
                                           input int          width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    return (wr_ptr - rd_ptr) & mask;
  endfunction

  function automatic logic at_least(input logic [31:0] cnt, input int level);
    return cnt >= $unsigned(level);
  endfunction

  function automatic logic at_most(input logic [31:0] cnt, input int level);
    return cnt <= $unsigned(level);
  endfunction

  function automatic fifo_flags_t calc_flags(input logic [31:0] cnt,
                                             input int          depth,
                                             input int          af_level,
                                             input int          ae_level);
    fifo_flags_t f;
    f.full         = (cnt == $unsigned(depth));
    f.almost_full  = at_least(cnt, af_level);
    f.empty        = (cnt == 32'd0);
    f.almost_empty = at_most(cnt, ae_level);
    return f;
  endfunction

endpackage

// File: rtl/simple_double_port_ram.sv
// rtl/simple_double_port_ram.sv - one write port, two registered read ports
module simple_double_port_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RAM_LENGTH = 1024,
  localparam int ADDR_W = clogb2(RAM_LENGTH)
) (
  input  logic                  wr_clk_i,
  input  logic                  wr_rst_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_clk_i,
  input  logic                  rd_rst_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic [ADDR_W-1:0]     rd_pre_addr_i,
  output logic [DATA_WIDTH-1:0] rd_pre_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [RAM_LENGTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_pre_data_q;

  // Contents are never cleared; reset only suppresses writes.
  always_ff @(posedge wr_clk_i) begin
    if (wr_en_i && !wr_rst_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge rd_clk_i) begin
    if (rd_rst_i) begin
      rd_data_q     <= '0;
      rd_pre_data_q <= '0;
    end else begin
      rd_data_q     <= mem_q[rd_addr_i];
      rd_pre_data_q <= mem_q[rd_pre_addr_i];
    end
  end

  assign rd_data_o     = rd_data_q;
  assign rd_pre_data_o = rd_pre_data_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - single-clock FIFO controller around a dual-port RAM
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1024,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2,
  localparam int ADDR_W    = clogb2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  full_o,
  output logic                  almost_full_o,
  output logic                  empty_o,
  output logic                  almost_empty_o,
  output logic [ADDR_W:0]       data_cnt_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int            CW      = ADDR_W + 1;
  localparam logic [CW-1:0] PTR_ONE = CW'(1);

  logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_d;
  fifo_flags_t           flags_q, flags_d;
  logic                  rd_valid_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] unused_pre_data;

  // Acceptance looks only at registered flags, so a full FIFO never takes a
  // write even if a read drains a slot in the same cycle.
  assign wr_acc = wr_en_i & ~flags_q.full;
  assign rd_acc = rd_en_i & ~flags_q.empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    cnt_d   = CW'(ptr_diff(32'(wr_ptr_d), 32'(rd_ptr_d), CW));
    flags_d = calc_flags(32'(cnt_d), DEPTH, AF_LEVEL, AE_LEVEL);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      flags_q     <= FLAGS_RESET;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      flags_q     <= flags_d;
      rd_valid_q  <= rd_acc;
      overflow_q  <= wr_en_i & flags_q.full;
      underflow_q <= rd_en_i & flags_q.empty;
    end
  end

  simple_double_port_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .RAM_LENGTH (DEPTH)
  ) u_ram (
    .wr_clk_i      (clk_i),
    .wr_rst_i      (rst_i),
    .wr_en_i       (wr_acc),
    .wr_addr_i     (wr_ptr_q[ADDR_W-1:0]),
    .wr_data_i     (wr_data_i),
    .rd_clk_i      (clk_i),
    .rd_rst_i      (rst_i),
    .rd_addr_i     (rd_ptr_q[ADDR_W-1:0]),
    .rd_data_o     (rd_data_o),
    .rd_pre_addr_i ({ADDR_W{1'b0}}),
    .rd_pre_data_o (unused_pre_data)
  );

  assign data_cnt_o     = CW'(ptr_diff(32'(wr_ptr_q), 32'(rd_ptr_q), CW));
  assign full_o         = flags_q.full;
  assign almost_full_o  = flags_q.almost_full;
  assign empty_o        = flags_q.empty;
  assign almost_empty_o = flags_q.almost_empty;
  assign rd_valid_o     = rd_valid_q;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule
